// File: rtl/hazard_bypass_unit_pkg.sv
// hazard_bypass_unit_pkg: opcodes, bubble instruction and operand/writer classification helpers.
package hazard_bypass_unit_pkg;
  localparam logic [6:0] OP_ALU = 7'b0110011;
  localparam logic [6:0] OP_ALUI = 7'b0010011;
  localparam logic [6:0] OP_LW = 7'b0000011;
  localparam logic [6:0] OP_SW = 7'b0100011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [31:0] NOP_INSN_DEF = 32'h00000013;
  typedef enum logic [1:0] {WR_NONE, WR_ALU, WR_LOAD} wr_class_e;
  function automatic wr_class_e writes_rd(input logic [6:0] op);
    return (op == OP_ALU || op == OP_ALUI) ? WR_ALU : (op == OP_LW) ? WR_LOAD : WR_NONE;
  endfunction
  function automatic logic reads_rs1(input logic [6:0] op);
    return op == OP_ALU || op == OP_ALUI || op == OP_LW || op == OP_SW || op == OP_BEQ;
  endfunction
  function automatic logic reads_rs2(input logic [6:0] op);
    return op == OP_ALU || op == OP_SW || op == OP_BEQ;
  endfunction
endpackage

// File: rtl/hazard_bypass_unit_bypass_match.sv
// hazard_bypass_unit_bypass_match: per-operand bypass select generation, younger producer wins.
module hazard_bypass_unit_bypass_match
  import hazard_bypass_unit_pkg::*;
(
  input  logic [4:0] rs,
  input  logic       reads,
  input  logic [4:0] exmem_rd,
  input  wr_class_e  exmem_cls,
  input  logic [4:0] memwb_rd,
  input  wr_class_e  memwb_cls,
  output logic       from_mem,
  output logic       from_alu_wb,
  output logic       from_ld_wb
);
  logic wb_hit;
  assign from_mem = reads && exmem_cls == WR_ALU && exmem_rd != 5'd0 && exmem_rd == rs;
  assign wb_hit = reads && memwb_rd != 5'd0 && memwb_rd == rs && !from_mem;
  assign from_alu_wb = wb_hit && memwb_cls == WR_ALU;
  assign from_ld_wb = wb_hit && memwb_cls == WR_LOAD;
endmodule

// File: rtl/hazard_bypass_unit.sv
// hazard_bypass_unit: shadow ID/EX, EX/MEM, MEM/WB IRs with load-use stall and operand bypass selects.
module hazard_bypass_unit
  import hazard_bypass_unit_pkg::*;
#(
  parameter logic [31:0] NOP_INSN = NOP_INSN_DEF,
  parameter int          CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             advance,
  input  logic             flush,
  input  logic [31:0]      IFIDIR,
  output logic [31:0]      IDEXIR,
  output logic [31:0]      EXMEMIR,
  output logic [31:0]      MEMWBIR,
  output logic             stall,
  output logic             bypassAfromMEM,
  output logic             bypassAfromALUinWB,
  output logic             bypassAfromLDinWB,
  output logic             bypassBfromMEM,
  output logic             bypassBfromALUinWB,
  output logic             bypassBfromLDinWB,
  output logic [CNT_W-1:0] stall_cycles
);
  logic [4:0] idex_rd;
  logic       idex_rs1_rd;
  logic       idex_rs2_rd;
  wr_class_e  exmem_cls;
  wr_class_e  memwb_cls;
  assign idex_rd = IDEXIR[11:7];
  assign idex_rs1_rd = reads_rs1(IDEXIR[6:0]);
  assign idex_rs2_rd = reads_rs2(IDEXIR[6:0]);
  assign exmem_cls = writes_rd(EXMEMIR[6:0]);
  assign memwb_cls = writes_rd(MEMWBIR[6:0]);
  // A load in ID/EX cannot forward to the decode instruction in time, so hold it one cycle.
  assign stall = IDEXIR[6:0] == OP_LW && idex_rd != 5'd0 &&
                 ((reads_rs1(IFIDIR[6:0]) && IFIDIR[19:15] == idex_rd) ||
                  (reads_rs2(IFIDIR[6:0]) && IFIDIR[24:20] == idex_rd));
  hazard_bypass_unit_bypass_match u_match_a (
    .rs(IDEXIR[19:15]), .reads(idex_rs1_rd),
    .exmem_rd(EXMEMIR[11:7]), .exmem_cls(exmem_cls),
    .memwb_rd(MEMWBIR[11:7]), .memwb_cls(memwb_cls),
    .from_mem(bypassAfromMEM), .from_alu_wb(bypassAfromALUinWB), .from_ld_wb(bypassAfromLDinWB)
  );
  hazard_bypass_unit_bypass_match u_match_b (
    .rs(IDEXIR[24:20]), .reads(idex_rs2_rd),
    .exmem_rd(EXMEMIR[11:7]), .exmem_cls(exmem_cls),
    .memwb_rd(MEMWBIR[11:7]), .memwb_cls(memwb_cls),
    .from_mem(bypassBfromMEM), .from_alu_wb(bypassBfromALUinWB), .from_ld_wb(bypassBfromLDinWB)
  );
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      IDEXIR <= NOP_INSN;
      EXMEMIR <= NOP_INSN;
      MEMWBIR <= NOP_INSN;
      stall_cycles <= '0;
    end else if (advance) begin
      IDEXIR <= (flush || stall) ? NOP_INSN : IFIDIR;
      EXMEMIR <= IDEXIR;
      MEMWBIR <= EXMEMIR;
      if (stall && !flush && !(&stall_cycles)) stall_cycles <= stall_cycles + 1'b1;
    end
  end
endmodule

// File: tb/tb_hazard_bypass_unit.sv
// tb_hazard_bypass_unit: directed pipeline scenarios checked through an expected-value scoreboard.
module tb_hazard_bypass_unit;
  localparam logic [31:0] NOP = 32'h00000013;
  localparam logic [31:0] ADD_X1 = 32'h003100B3;
  localparam logic [31:0] ADD_X4_X1_X5 = 32'h00508233;
  localparam logic [31:0] LW_X1 = 32'h00012083;
  localparam logic [31:0] ADD_X4_X1_X1 = 32'h00108233;
  localparam logic [31:0] ADDI_X0 = 32'h00100013;
  localparam logic [31:0] ADD_X4_X0_X5 = 32'h00500233;
  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        advance = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] IFIDIR = NOP;
  logic [31:0] IDEXIR, EXMEMIR, MEMWBIR;
  logic        stall;
  logic        a_mem, a_alu, a_ld, b_mem, b_alu, b_ld;
  logic [15:0] stall_cycles;
  logic [5:0]  byp;
  int          total = 0;
  int          bad = 0;
  string       tag_q[$];
  logic [63:0] exp_q[$];
  hazard_bypass_unit dut (
    .clock(clock), .reset_n(reset_n), .advance(advance), .flush(flush), .IFIDIR(IFIDIR),
    .IDEXIR(IDEXIR), .EXMEMIR(EXMEMIR), .MEMWBIR(MEMWBIR), .stall(stall),
    .bypassAfromMEM(a_mem), .bypassAfromALUinWB(a_alu), .bypassAfromLDinWB(a_ld),
    .bypassBfromMEM(b_mem), .bypassBfromALUinWB(b_alu), .bypassBfromLDinWB(b_ld),
    .stall_cycles(stall_cycles)
  );
  assign byp = {a_mem, a_alu, a_ld, b_mem, b_alu, b_ld};
  always #5 clock = ~clock;
  task automatic push(input string t, input logic [63:0] v);
    tag_q.push_back(t);
    exp_q.push_back(v);
  endtask
  task automatic chk(input logic [63:0] obs);
    string t;
    logic [63:0] e;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $error("FAIL scoreboard_empty obs=%0h", obs);
    end else begin
      t = tag_q.pop_front();
      e = exp_q.pop_front();
      assert (obs === e) else begin
        bad++;
        $error("FAIL %s obs=%0h exp=%0h", t, obs, e);
      end
    end
  endtask
  task automatic step();
    @(posedge clock);
    #1;
  endtask
  task automatic issue(input logic [31:0] insn);
    IFIDIR = insn;
    step();
  endtask
  initial begin
    advance = 1'b0;
    repeat (2) step();
    reset_n = 1'b1;
    step();
    push("rst_idex", NOP); push("rst_exmem", NOP); push("rst_memwb", NOP);
    push("rst_byp", 0); push("rst_stall", 0); push("rst_cnt", 0);
    chk(IDEXIR); chk(EXMEMIR); chk(MEMWBIR); chk(byp); chk(stall); chk(stall_cycles);
    advance = 1'b1;
    issue(ADD_X1);
    issue(ADD_X4_X1_X5);
    push("alu_mem_idex", ADD_X4_X1_X5); push("alu_mem_byp", 6'b100_000);
    chk(IDEXIR); chk(byp);
    issue(ADD_X1);
    issue(NOP);
    issue(ADD_X4_X1_X5);
    push("alu_wb_byp", 6'b010_000);
    chk(byp);
    issue(LW_X1);
    IFIDIR = ADD_X4_X1_X5;
    #1;
    push("lu_stall", 1);
    chk(stall);
    step();
    push("lu_bubble_idex", NOP); push("lu_bubble_exmem", LW_X1);
    push("lu_bubble_stall", 0); push("lu_cnt", 1);
    chk(IDEXIR); chk(EXMEMIR); chk(stall); chk(stall_cycles);
    step();
    push("lu_use_idex", ADD_X4_X1_X5); push("lu_use_byp", 6'b001_000);
    chk(IDEXIR); chk(byp);
    issue(ADD_X1);
    issue(ADD_X1);
    issue(ADD_X4_X1_X1);
    push("both_mem_byp", 6'b100_100);
    chk(byp);
    issue(ADDI_X0);
    issue(ADD_X4_X0_X5);
    push("x0_idex", ADD_X4_X0_X5); push("x0_byp", 0);
    chk(IDEXIR); chk(byp);
    issue(LW_X1);
    IFIDIR = ADD_X4_X1_X5;
    flush = 1'b1;
    #1;
    push("fl_stall", 1);
    chk(stall);
    step();
    flush = 1'b0;
    push("fl_idex", NOP); push("fl_cnt", 1);
    chk(IDEXIR); chk(stall_cycles);
    issue(LW_X1);
    IFIDIR = ADD_X4_X1_X5;
    advance = 1'b0;
    repeat (3) step();
    push("frz_idex", LW_X1); push("frz_exmem", NOP); push("frz_memwb", LW_X1);
    push("frz_stall", 1); push("frz_cnt", 1);
    chk(IDEXIR); chk(EXMEMIR); chk(MEMWBIR); chk(stall); chk(stall_cycles);
    advance = 1'b1;
    step();
    push("thaw_idex", NOP); push("thaw_cnt", 2);
    chk(IDEXIR); chk(stall_cycles);
    issue(LW_X1);
    IFIDIR = ADD_X4_X1_X5;
    #1;
    push("mid_stall", 1);
    chk(stall);
    #2;
    reset_n = 1'b0;
    #1;
    push("arst_idex", NOP); push("arst_exmem", NOP); push("arst_memwb", NOP);
    push("arst_stall", 0); push("arst_cnt", 0);
    chk(IDEXIR); chk(EXMEMIR); chk(MEMWBIR); chk(stall); chk(stall_cycles);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
